// File: rtl/grant_decoder.sv
// grant_decoder: turns an encoded grant index plus valid into a registered one-hot grant.
// A grant is held until the granted requester releases it, then one all-zero GAP cycle
// follows, so consecutive grants are always break-before-make.
// Optional hold-time limit: define GRANT_TIMEOUT_EN to revoke a grant after TIMEOUT cycles.
module grant_decoder #(
   parameter int unsigned N       = 8,
   parameter int unsigned IDX_W   = $clog2(N),
   parameter int unsigned TIMEOUT = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [IDX_W-1:0] in_idx,
   input  logic             in_valid,
   output logic             in_ready,
   output logic [N-1:0]     gnt_oh,
   output logic             gnt_active,
   input  logic [N-1:0]     release_i,
   output logic             idx_err,
   output logic             timeout_o
);

   // One wider than the index so N itself is representable when N is a power of two.
   localparam logic [IDX_W:0] NumReq  = (IDX_W + 1)'(N);
   localparam logic [N-1:0]   OneHot0 = {{(N - 1){1'b0}}, 1'b1};

   typedef enum logic [1:0] {StIdle, StGrant, StGap} state_e;

   state_e             state_q, state_d;
   logic [IDX_W-1:0]   idx_q, idx_d;
   logic [N-1:0]       gnt_q, gnt_d;
   logic               idx_err_q, idx_err_d;
   logic               in_range;
   logic               rel_held;
   logic               tmo_hit;

   assign in_range = ({1'b0, in_idx} < NumReq);
   // Only the release bit of the currently held requester counts.
   assign rel_held = release_i[idx_q];

`ifdef GRANT_TIMEOUT_EN
   localparam int unsigned    CntW    = $clog2(TIMEOUT + 1);
   localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT - 1);
   localparam logic [CntW-1:0] CntMax  = {CntW{1'b1}};

   logic [CntW-1:0] cnt_q, cnt_d;
   logic            tmo_q;

   // Release on the same edge wins over the timeout.
   assign tmo_hit = (state_q == StGrant) && !rel_held && (cnt_q == CntLast);

   // Hold counter: cleared on grant entry, counts GRANT cycles, saturates.
   always_comb begin
      cnt_d = cnt_q;
      if (state_q == StIdle && in_valid && in_range) begin
         cnt_d = '0;
      end else if (state_q == StGrant && !rel_held && cnt_q != CntMax) begin
         cnt_d = cnt_q + CntW'(1);
      end
   end

   // Hold counter and timeout pulse registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
         tmo_q <= 1'b0;
      end else begin
         cnt_q <= cnt_d;
         tmo_q <= tmo_hit;
      end
   end

   assign timeout_o = tmo_q;
`else
   assign tmo_hit   = 1'b0;
   assign timeout_o = 1'b0;
`endif

   // FSM state register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   // FSM next-state logic.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle: begin
            if (in_valid && in_range) state_d = StGrant;
         end
         StGrant: begin
            if (rel_held || tmo_hit) state_d = StGap;
         end
         StGap: begin
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   // Next values of the registered outputs and the held index.
   always_comb begin
      gnt_d     = gnt_q;
      idx_d     = idx_q;
      idx_err_d = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (in_valid) begin
               if (in_range) begin
                  idx_d = in_idx;
                  gnt_d = OneHot0 << in_idx;
               end else begin
                  idx_err_d = 1'b1;
               end
            end
         end
         StGrant: begin
            if (rel_held || tmo_hit) gnt_d = '0;
         end
         StGap: begin
            gnt_d = '0;
         end
         default: begin
            gnt_d = '0;
         end
      endcase
   end

   // Grant, held index and error pulse registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         gnt_q     <= '0;
         idx_q     <= '0;
         idx_err_q <= 1'b0;
      end else begin
         gnt_q     <= gnt_d;
         idx_q     <= idx_d;
         idx_err_q <= idx_err_d;
      end
   end

   assign in_ready   = (state_q == StIdle);
   assign gnt_oh     = gnt_q;
   assign gnt_active = |gnt_q;
   assign idx_err    = idx_err_q;

endmodule

// File: tb/tb_grant_decoder.sv
// Scoreboard bench for grant_decoder: stimulus pushes expected events (grant rise/fall,
// ready rise, idx_err, timeout) tagged with cycle numbers; a monitor pops and compares.
module tb_grant_decoder;

   localparam int EvRise  = 0;
   localparam int EvFall  = 1;
   localparam int EvReady = 2;
   localparam int EvErr   = 3;
   localparam int EvTmo   = 4;

   typedef struct {
      int         dut;
      int         kind;
      logic [7:0] val;
      int         cyc;
   } ev_t;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   int         cyc = 0;

   logic [2:0] in_idx8 = '0;
   logic       in_valid8 = 1'b0;
   logic [7:0] rel8 = '0;
   logic       rdy8, act8, err8, tmo8;
   logic [7:0] gnt8;

   logic [2:0] in_idx6 = '0;
   logic       in_valid6 = 1'b0;
   logic [5:0] rel6 = '0;
   logic       rdy6, act6, err6, tmo6;
   logic [5:0] gnt6;

   ev_t        exp_q[$];
   int         rd = 0;
   int         n_chk = 0;
   int         n_fail = 0;
   logic       done = 1'b0;

   grant_decoder #(.N(8), .IDX_W(3), .TIMEOUT(16)) dut8 (
      .clk        (clk),
      .rst_n      (rst_n),
      .in_idx     (in_idx8),
      .in_valid   (in_valid8),
      .in_ready   (rdy8),
      .gnt_oh     (gnt8),
      .gnt_active (act8),
      .release_i  (rel8),
      .idx_err    (err8),
      .timeout_o  (tmo8)
   );

   grant_decoder #(.N(6), .IDX_W(3), .TIMEOUT(16)) dut6 (
      .clk        (clk),
      .rst_n      (rst_n),
      .in_idx     (in_idx6),
      .in_valid   (in_valid6),
      .in_ready   (rdy6),
      .gnt_oh     (gnt6),
      .gnt_active (act6),
      .release_i  (rel6),
      .idx_err    (err6),
      .timeout_o  (tmo6)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // ---------------- checking helpers (monitor process only) ----------------
   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
      n_chk++;
      if (got !== want) begin
         n_fail++;
         $display("FAIL %s at cycle %0d: got %h, want %h", name, cyc, got, want);
      end
   endtask

   task automatic got_ev(input int d, input int k, input logic [7:0] v);
      logic [31:0] act;
      logic [31:0] want;
      int          dd;
      int          kk;
      int          cc;
      act = {d[3:0], k[3:0], v, cyc[15:0]};
      if (rd >= exp_q.size()) begin
         n_chk++;
         n_fail++;
         $display("FAIL event at cycle %0d: got unexpected %h (dut/kind/val/cycle)", cyc, act);
      end else begin
         dd   = exp_q[rd].dut;
         kk   = exp_q[rd].kind;
         cc   = exp_q[rd].cyc;
         want = {dd[3:0], kk[3:0], exp_q[rd].val, cc[15:0]};
         rd++;
         chk("event", act, want);
      end
   endtask

   // ---------------- monitor ----------------
   initial begin : monitor
      logic [7:0] pg8;
      logic [7:0] pg6;
      logic       pr8;
      logic       pr6;
      logic       prst;
      pg8 = '0; pg6 = '0; pr8 = 1'b1; pr6 = 1'b1; prst = 1'b0;
      forever begin
         @(negedge clk or negedge rst_n);
         if (!rst_n) begin
            if (prst) begin
               // Reset asserted mid-run: outputs must clear without waiting for a clock.
               #1;
               chk("async_gnt8", {24'd0, gnt8}, 32'h0);
               chk("async_act8", {31'd0, act8}, 32'h0);
               chk("async_rdy8", {31'd0, rdy8}, 32'h1);
               chk("async_pulses8", {30'd0, err8, tmo8}, 32'h0);
            end
            prst = 1'b0;
            pg8 = '0; pg6 = '0; pr8 = 1'b1; pr6 = 1'b1;
         end else begin
            if (!prst) begin
               chk("rst_gnt8", {24'd0, gnt8}, 32'h0);
               chk("rst_rdy8", {31'd0, rdy8}, 32'h1);
               chk("rst_act8", {31'd0, act8}, 32'h0);
               chk("rst_pulses8", {30'd0, err8, tmo8}, 32'h0);
               chk("rst_gnt6", {26'd0, gnt6}, 32'h0);
               chk("rst_rdy6", {31'd0, rdy6}, 32'h1);
               chk("rst_pulses6", {30'd0, err6, tmo6}, 32'h0);
               prst = 1'b1;
            end
            // Fixed per-sample order; stimulus pushes same-cycle events in this order.
            if (tmo8) got_ev(0, EvTmo, 8'h00);
            if (pg8 != 0 && gnt8 == 0) got_ev(0, EvFall, 8'h00);
            if (!pr8 && rdy8) got_ev(0, EvReady, 8'h00);
            if (err8) got_ev(0, EvErr, 8'h00);
            if (pg8 == 0 && gnt8 != 0) begin
               got_ev(0, EvRise, gnt8);
               chk("rise_ready8", {31'd0, rdy8}, 32'h0);
            end
            chk("onehot8", {31'd0, $onehot0(gnt8)}, 32'h1);
            chk("active8", {31'd0, act8}, {31'd0, (gnt8 != 0)});
            chk("no_make8", {31'd0, (pg8 != 0 && gnt8 != 0 && gnt8 != pg8)}, 32'h0);
            pg8 = gnt8;
            pr8 = rdy8;

            if (tmo6) got_ev(1, EvTmo, 8'h00);
            if (pg6 != 0 && gnt6 == 0) got_ev(1, EvFall, 8'h00);
            if (!pr6 && rdy6) got_ev(1, EvReady, 8'h00);
            if (err6) begin
               got_ev(1, EvErr, 8'h00);
               chk("err_ready6", {31'd0, rdy6}, 32'h1);
               chk("err_nogrant6", {26'd0, gnt6}, 32'h0);
            end
            if (pg6 == 0 && gnt6 != 0) got_ev(1, EvRise, {2'b00, gnt6});
            chk("onehot6", {31'd0, $onehot0(gnt6)}, 32'h1);
            pg6 = {2'b00, gnt6};
            pr6 = rdy6;
         end

         if (done || cyc > 4000) begin
            if (!done) begin
               n_chk++;
               n_fail++;
               $display("FAIL watchdog: stimulus did not complete by cycle %0d", cyc);
            end
            chk("pending_events", rd, exp_q.size());
            $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
            $finish;
         end
      end
   end

   // ---------------- stimulus ----------------
   task automatic tick();
      @(negedge clk);
   endtask

   task automatic expect_ev(input int d, input int k, input logic [7:0] v, input int c);
      ev_t e;
      e.dut  = d;
      e.kind = k;
      e.val  = v;
      e.cyc  = c;
      exp_q.push_back(e);
   endtask

   initial begin : stimulus
      int c;
      repeat (3) tick();
      #2 rst_n = 1'b1;
      repeat (2) tick();

      // Basic grant of idx 3, released after three grant cycles.
      c = cyc;
      in_idx8 = 3'd3; in_valid8 = 1'b1;
      expect_ev(0, EvRise, 8'h08, c + 1);
      tick(); in_valid8 = 1'b0;
      tick(); tick();
      rel8 = 8'h08;
      expect_ev(0, EvFall, 8'h00, c + 4);
      expect_ev(0, EvReady, 8'h00, c + 5);
      tick(); rel8 = '0;
      tick(); tick();

      // Grant idx 7, wrong releases for 5 cycles, idx 0 pending throughout.
      c = cyc;
      in_idx8 = 3'd7; in_valid8 = 1'b1;
      expect_ev(0, EvRise, 8'h80, c + 1);
      tick(); in_idx8 = 3'd0; rel8 = 8'h7F;
      repeat (5) tick();
      rel8 = 8'h80;
      expect_ev(0, EvFall, 8'h00, c + 7);
      expect_ev(0, EvReady, 8'h00, c + 8);
      expect_ev(0, EvRise, 8'h01, c + 9);
      tick(); tick(); tick();
      in_valid8 = 1'b0; rel8 = '0;
      tick();
      rel8 = 8'h01;
      expect_ev(0, EvFall, 8'h00, c + 11);
      expect_ev(0, EvReady, 8'h00, c + 12);
      tick(); rel8 = '0;
      tick(); tick();

      // Release present on the accept edge must not end the new grant.
      c = cyc;
      in_idx8 = 3'd4; in_valid8 = 1'b1; rel8 = 8'h10;
      expect_ev(0, EvRise, 8'h10, c + 1);
      tick(); in_valid8 = 1'b0; rel8 = '0;
      tick(); tick();
      rel8 = 8'h10;
      expect_ev(0, EvFall, 8'h00, c + 4);
      expect_ev(0, EvReady, 8'h00, c + 5);
      tick(); rel8 = '0;
      tick(); tick();

      // Long hold of idx 2: revoked after 16 cycles only with the timeout feature.
      c = cyc;
      in_idx8 = 3'd2; in_valid8 = 1'b1;
      expect_ev(0, EvRise, 8'h04, c + 1);
      tick(); in_valid8 = 1'b0;
`ifdef GRANT_TIMEOUT_EN
      expect_ev(0, EvTmo, 8'h00, c + 17);
      expect_ev(0, EvFall, 8'h00, c + 17);
      expect_ev(0, EvReady, 8'h00, c + 18);
`endif
      repeat (19) tick();
      rel8 = 8'h04;
`ifndef GRANT_TIMEOUT_EN
      expect_ev(0, EvFall, 8'h00, c + 21);
      expect_ev(0, EvReady, 8'h00, c + 22);
`endif
      tick(); rel8 = '0;
      tick(); tick();

      // Release on the 16th grant cycle: normal release, never a timeout.
      c = cyc;
      in_idx8 = 3'd2; in_valid8 = 1'b1;
      expect_ev(0, EvRise, 8'h04, c + 1);
      tick(); in_valid8 = 1'b0;
      repeat (15) tick();
      rel8 = 8'h04;
      expect_ev(0, EvFall, 8'h00, c + 17);
      expect_ev(0, EvReady, 8'h00, c + 18);
      tick(); rel8 = '0;
      tick(); tick();

      // Reset asserted mid-grant of idx 5.
      c = cyc;
      in_idx8 = 3'd5; in_valid8 = 1'b1;
      expect_ev(0, EvRise, 8'h20, c + 1);
      tick(); in_valid8 = 1'b0;
      tick(); tick();
      #3 rst_n = 1'b0;
      tick();
      #2 rst_n = 1'b1;
      tick(); tick();

      // N=6 instance: out-of-range indices then a valid grant of idx 5.
      c = cyc;
      in_idx6 = 3'd6; in_valid6 = 1'b1;
      expect_ev(1, EvErr, 8'h00, c + 1);
      tick(); in_valid6 = 1'b0;
      tick(); tick();
      c = cyc;
      in_idx6 = 3'd7; in_valid6 = 1'b1;
      expect_ev(1, EvErr, 8'h00, c + 1);
      tick(); in_idx6 = 3'd5;
      expect_ev(1, EvRise, 8'h20, c + 2);
      tick(); in_valid6 = 1'b0;
      tick();
      rel6 = 6'h20;
      expect_ev(1, EvFall, 8'h00, c + 4);
      expect_ev(1, EvReady, 8'h00, c + 5);
      tick(); rel6 = '0;
      repeat (3) tick();

      done = 1'b1;
   end

endmodule
